// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST sequencer: state encoding,
// LFSR/MISR widths and taps, and the LFSR step and seed fix-up helpers.
package s27_bist_pkg;

  localparam int LFSR_W = 4;
  localparam int MISR_W = 8;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;
  localparam logic [MISR_W-1:0] MISR_TAPS = 8'b1011_1000;
  localparam logic [LFSR_W-1:0] SEED_FIX  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  // x^4+x^3+1 Fibonacci step, period 15 from any non-zero state
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by SEED_FIX
  function automatic logic [LFSR_W-1:0] seed_fixup(input logic [LFSR_W-1:0] s);
    return (s == '0) ? SEED_FIX : s;
  endfunction

endpackage

// File: rtl/s27_misr.sv
// Serial signature register that compacts one response bit per enabled edge.
// Clear has priority over enable.
module s27_misr
  import s27_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[MISR_W-2:0], (^(sig & MISR_TAPS)) ^ din};
    end
  end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST sequencer for the s27 core: flush, LFSR pattern run, G17 compaction.
// Optional ABORT input is enabled by defining S27_BIST_ABORT_EN.
module s27_bist_ctrl
  import s27_bist_pkg::*;
#(
  parameter int                FLUSH_CYCLES = 2,
  parameter logic [LFSR_W-1:0] FLUSH_PAT    = 4'b1100,
  parameter int                N_PAT        = 15,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = 8'h00
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              START,
  input  logic [LFSR_W-1:0] SEED,
`ifdef S27_BIST_ABORT_EN
  input  logic              ABORT,
`endif
  output logic [LFSR_W-1:0] DUT_G,
  input  logic              DUT_G17,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [MISR_W-1:0] SIG,
  output bist_state_e       dbg_state
);

  localparam int                FC_W     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [7:0]        PAT_LAST = 8'(N_PAT);

  bist_state_e       state;
  logic [LFSR_W-1:0] lfsr;
  logic [FC_W-1:0]   flush_cnt;
  logic [7:0]        pat_cnt;
  logic              abort;
  logic              start_accept;
  logic              misr_en;

`ifdef S27_BIST_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  // START is a level request without a ready: it is taken on any edge in
  // IDLE or DONE and ignored while BUSY is high.
  assign start_accept = ((state == ST_IDLE) || (state == ST_DONE)) && START;

  // One G17 sample per applied pattern; the final RUN edge only concludes.
  assign misr_en = (state == ST_RUN) && (pat_cnt != PAT_LAST) && !abort;

  assign dbg_state = state;

  s27_misr u_misr (
    .clk (CK),
    .rst (RST),
    .clr (start_accept),
    .en  (misr_en),
    .din (DUT_G17),
    .sig (SIG)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      DUT_G     <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      lfsr      <= SEED_FIX;
      flush_cnt <= '0;
      pat_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            state     <= ST_FLUSH;
            DUT_G     <= FLUSH_PAT;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            lfsr      <= seed_fixup(SEED);
            flush_cnt <= '0;
            pat_cnt   <= '0;
          end
        end
        ST_FLUSH: begin
          if (abort) begin
            state <= ST_IDLE;
            DUT_G <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
          end else if (flush_cnt == FC_LAST) begin
            state <= ST_RUN;
            DUT_G <= lfsr;
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
            DUT_G <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            PASS  <= 1'b0;
          end else if (pat_cnt == PAT_LAST) begin
            state <= ST_DONE;
            DUT_G <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (SIG == GOLDEN_SIG);
          end else begin
            // lfsr always mirrors the pattern currently on DUT_G
            lfsr    <= lfsr_step(lfsr);
            DUT_G   <= lfsr_step(lfsr);
            pat_cnt <= pat_cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Bench for s27_bist_ctrl: three instances differing only in GOLDEN_SIG,
// fed either by bench-driven G17 bits or by a behavioural s27 core.
module tb_s27_bist_ctrl;
  import s27_bist_pkg::*;

  localparam int         FLUSH_CYCLES = 2;
  localparam logic [3:0] FLUSH_PAT    = 4'b1100;
  localparam int         N_PAT        = 15;

  // Maximal-length sequence order of x^4+x^3+1, listed from value 1
  function automatic logic [3:0] seq_at(input int k);
    logic [3:0] v;
    case (k % 15)
      0:       v = 4'h1;
      1:       v = 4'h2;
      2:       v = 4'h4;
      3:       v = 4'h9;
      4:       v = 4'h3;
      5:       v = 4'h6;
      6:       v = 4'hD;
      7:       v = 4'hA;
      8:       v = 4'h5;
      9:       v = 4'hB;
      10:      v = 4'h7;
      11:      v = 4'hF;
      12:      v = 4'hE;
      13:      v = 4'hC;
      default: v = 4'h8;
    endcase
    return v;
  endfunction

  // Seed 0 behaves like seed 1, which sits at position 0
  function automatic int seq_idx(input logic [3:0] s);
    int idx;
    idx = 0;
    for (int k = 0; k < 15; k++) begin
      if (seq_at(k) == s) idx = k;
    end
    return idx;
  endfunction

  function automatic logic [3:0] exp_pat(input logic [3:0] sd, input int i);
    return seq_at(seq_idx(sd) + i);
  endfunction

  function automatic logic [7:0] fold_sig(input logic [14:0] bits);
    logic [7:0] s;
    logic       fb;
    s = 8'h00;
    for (int j = 0; j < N_PAT; j++) begin
      fb = s[7] ^ s[5] ^ s[4] ^ s[3] ^ bits[j];
      s  = {s[6:0], fb};
    end
    return s;
  endfunction

  // G17 of s27 for each pattern, starting from the flushed state (0,1,0)
  function automatic logic [14:0] core_bits(input logic [3:0] sd);
    logic [14:0] b;
    logic [3:0]  p;
    logic s5, s6, s7, n8, n9, n10, n11, n12, n13, n14, n15, n16;
    s5 = 1'b0; s6 = 1'b1; s7 = 1'b0;
    b = '0;
    for (int i = 0; i < N_PAT; i++) begin
      p   = exp_pat(sd, i);
      n14 = ~p[0];
      n12 = ~(p[1] | s7);
      n13 = ~(p[2] | n12);
      n8  = n14 & s6;
      n15 = n12 | n8;
      n16 = p[3] | n8;
      n9  = ~(n16 & n15);
      n11 = ~(s5 | n9);
      n10 = ~(n14 | n11);
      b[i] = ~n11;
      s5 = n10; s6 = n11; s7 = n13;
    end
    return b;
  endfunction

  localparam logic [7:0] CORE_SIG = fold_sig(core_bits(4'h9));

  logic       ck;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic       g17_tb;
  logic       use_core;
  logic       g17_mux;
`ifdef S27_BIST_ABORT_EN
  logic       abort;
`endif

  logic [3:0]  dut_g_a, dut_g_b, dut_g_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [7:0]  sig_a, sig_b, sig_c;
  bist_state_e state_a, state_b, state_c;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Behavioural s27 core driven by instance a, flops without reset
  logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16, core_g17;
  logic       core_scr;
  logic [2:0] scr_val;

  always_comb begin
    g14      = ~dut_g_a[0];
    g12      = ~(dut_g_a[1] | g7);
    g13      = ~(dut_g_a[2] | g12);
    g8       = g14 & g6;
    g15      = g12 | g8;
    g16      = dut_g_a[3] | g8;
    g9       = ~(g16 & g15);
    g11      = ~(g5 | g9);
    g10      = ~(g14 | g11);
    core_g17 = ~g11;
  end

  always @(posedge ck) begin
    if (core_scr) begin
      {g5, g6, g7} <= scr_val;
    end else begin
      g5 <= g10;
      g6 <= g11;
      g7 <= g13;
    end
  end

  assign g17_mux = use_core ? core_g17 : g17_tb;

  s27_bist_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .FLUSH_PAT(FLUSH_PAT), .N_PAT(N_PAT),
                  .GOLDEN_SIG(8'h00)) dut_a (
    .CK(ck), .RST(rst), .START(start), .SEED(seed),
`ifdef S27_BIST_ABORT_EN
    .ABORT(abort),
`endif
    .DUT_G(dut_g_a), .DUT_G17(g17_mux), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .SIG(sig_a), .dbg_state(state_a)
  );

  s27_bist_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .FLUSH_PAT(FLUSH_PAT), .N_PAT(N_PAT),
                  .GOLDEN_SIG(CORE_SIG)) dut_b (
    .CK(ck), .RST(rst), .START(start), .SEED(seed),
`ifdef S27_BIST_ABORT_EN
    .ABORT(abort),
`endif
    .DUT_G(dut_g_b), .DUT_G17(g17_mux), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .SIG(sig_b), .dbg_state(state_b)
  );

  s27_bist_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .FLUSH_PAT(FLUSH_PAT), .N_PAT(N_PAT),
                  .GOLDEN_SIG(CORE_SIG ^ 8'h01)) dut_c (
    .CK(ck), .RST(rst), .START(start), .SEED(seed),
`ifdef S27_BIST_ABORT_EN
    .ABORT(abort),
`endif
    .DUT_G(dut_g_c), .DUT_G17(g17_mux), .BUSY(busy_c), .DONE(done_c),
    .PASS(pass_c), .SIG(sig_c), .dbg_state(state_c)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; seed = 4'h0; g17_tb = 1'b0; use_core = 1'b0;
    core_scr = 1'b0; scr_val = 3'b000;
`ifdef S27_BIST_ABORT_EN
    abort = 1'b0;
`endif
    tick; tick;
    checks++;
    if ({dut_g_a, sig_a, busy_a, done_a, pass_a} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", {dut_g_a, sig_a, busy_a, done_a, pass_a}, 15'h0);
    end
    checks++;
    if (state_a !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state_a, ST_IDLE);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (state_a !== ST_IDLE || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got state %0d busy %b expected state 0 busy 0", state_a, busy_a);
    end
  endtask

  // One complete run from IDLE or DONE; rnd supplies G17 bits unless core_mode
  task automatic run_check(input logic [3:0] sd, input logic core_mode, input logic [14:0] rnd,
                           input logic junk, input logic poke_start, input string tag);
    logic [7:0]  exp_sig;
    logic [3:0]  exp_g;
    int          k;
    exp_q.delete();
    for (int i = 0; i < N_PAT; i++) exp_q.push_back(exp_pat(sd, i));
    exp_sig  = fold_sig(core_mode ? core_bits(sd) : rnd);
    use_core = core_mode;
    if (core_mode) begin
      core_scr = 1'b1;
      scr_val  = 3'($urandom_range(0, 7));
      tick;
      core_scr = 1'b0;
    end
    start = 1'b1; seed = sd;
    g17_tb = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    tick;
    start = 1'b0; seed = 4'($urandom_range(0, 15));
    checks++;
    if ({dut_g_a, busy_a, done_a, pass_a, sig_a} !== {FLUSH_PAT, 3'b100, 8'h00}) begin
      errors++;
      $display("FAIL %s start_edge: got %h expected %h", tag, {dut_g_a, busy_a, done_a, pass_a, sig_a},
               {FLUSH_PAT, 3'b100, 8'h00});
    end
    k = 0;
    while (done_a !== 1'b1 && k < 40) begin
      if (k >= 2 && k <= 16) g17_tb = rnd[k-2];
      else g17_tb = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      if (poke_start && (k == 1 || k == 6)) begin
        start = 1'b1;
        seed  = 4'($urandom_range(0, 15));
      end
      tick;
      k++;
      start = 1'b0;
      if (k == 1) begin
        checks++;
        if (dut_g_a !== FLUSH_PAT) begin
          errors++;
          $display("FAIL %s flush_pat: got %h expected %h", tag, dut_g_a, FLUSH_PAT);
        end
      end
      if (k >= 2 && k <= 16) begin
        exp_g = exp_q.pop_front();
        checks++;
        if (dut_g_a !== exp_g) begin
          errors++;
          $display("FAIL %s pattern %0d: got %h expected %h", tag, k - 2, dut_g_a, exp_g);
        end
        if (core_mode) begin
          checks++;
          if ($isunknown(core_g17)) begin
            errors++;
            $display("FAIL %s g17_known %0d: got %b expected 0 or 1", tag, k - 2, core_g17);
          end
        end
      end
    end
    checks++;
    if (k !== FLUSH_CYCLES + N_PAT + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, k, FLUSH_CYCLES + N_PAT + 1);
    end
    checks++;
    if (sig_a !== exp_sig) begin
      errors++;
      $display("FAIL %s signature: got %h expected %h", tag, sig_a, exp_sig);
    end
    checks++;
    if ({pass_a, pass_b, pass_c} !== {exp_sig == 8'h00, exp_sig == CORE_SIG, exp_sig == (CORE_SIG ^ 8'h01)}) begin
      errors++;
      $display("FAIL %s pass: got %b expected %b", tag, {pass_a, pass_b, pass_c},
               {exp_sig == 8'h00, exp_sig == CORE_SIG, exp_sig == (CORE_SIG ^ 8'h01)});
    end
    checks++;
    if ({dut_g_a, busy_a, state_a} !== {4'h0, 1'b0, ST_DONE}) begin
      errors++;
      $display("FAIL %s done_outputs: got %h expected %h", tag, {dut_g_a, busy_a, state_a}, {4'h0, 1'b0, ST_DONE});
    end
    checks++;
    if ({dut_g_b, busy_b, done_b, sig_b, state_b} !== {4'h0, 2'b01, exp_sig, ST_DONE} ||
        {dut_g_c, busy_c, done_c, sig_c, state_c} !== {4'h0, 2'b01, exp_sig, ST_DONE}) begin
      errors++;
      $display("FAIL %s peer_instances: got %h / %h expected %h", tag, {dut_g_b, busy_b, done_b, sig_b, state_b},
               {dut_g_c, busy_c, done_c, sig_c, state_c}, {4'h0, 2'b01, exp_sig, ST_DONE});
    end
  endtask

  task automatic test_zero_response;
    run_check(4'h1, 1'b0, 15'h0000, 1'b0, 1'b0, "zero_response");
  endtask

  task automatic test_seed_fixup;
    run_check(4'h0, 1'b0, 15'h0000, 1'b0, 1'b0, "seed_fixup_zero");
    run_check(4'h0, 1'b0, 15'($urandom), 1'b1, 1'b0, "seed_fixup_rand");
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      run_check(4'($urandom_range(0, 15)), 1'b0, 15'($urandom), 1'b1, 1'b0, "random");
    end
  endtask

  task automatic test_core;
    run_check(4'h9, 1'b1, 15'h0000, 1'b0, 1'b0, "core_seed9");
  endtask

  task automatic test_back_to_back;
    run_check(4'hA, 1'b0, 15'($urandom), 1'b1, 1'b1, "start_poke");
    run_check(4'h7, 1'b0, 15'h7FFF, 1'b1, 1'b0, "restart_from_done");
  endtask

  task automatic test_reset_mid_run;
    use_core = 1'b0; g17_tb = 1'b1;
    start = 1'b1; seed = 4'h5;
    tick;
    start = 1'b0;
    repeat (8) tick;
    checks++;
    if (state_a !== ST_RUN || sig_a === 8'h00) begin
      errors++;
      $display("FAIL reset_mid_run_pre: got state %0d sig %h expected state 2 sig nonzero", state_a, sig_a);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dut_g_a, sig_a, busy_a, done_a, pass_a} !== 15'h0 || state_a !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_mid_run_async: got %h state %0d expected 0 state 0",
               {dut_g_a, sig_a, busy_a, done_a, pass_a}, state_a);
    end
    @(posedge ck);
    #1 rst = 1'b0;
    tick;
    checks++;
    if (state_a !== ST_IDLE || busy_a !== 1'b0 || dut_g_a !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_run_idle: got state %0d busy %b g %h expected 0 0 0", state_a, busy_a, dut_g_a);
    end
  endtask

`ifdef S27_BIST_ABORT_EN
  task automatic test_abort;
    logic [7:0] sig_hold;
    use_core = 1'b0;
    start = 1'b1; seed = 4'h1;
    tick;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      g17_tb = 1'($urandom_range(0, 1));
      tick;
    end
    checks++;
    if (state_a !== ST_RUN || dut_g_a !== exp_pat(4'h1, 5)) begin
      errors++;
      $display("FAIL abort_pre: got state %0d g %h expected state 2 g %h", state_a, dut_g_a, exp_pat(4'h1, 5));
    end
    sig_hold = sig_a;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({dut_g_a, busy_a, done_a, pass_a, state_a} !== {4'h0, 3'b000, ST_IDLE} || sig_a !== sig_hold) begin
      errors++;
      $display("FAIL abort_idle: got %h sig %h expected %h sig %h", {dut_g_a, busy_a, done_a, pass_a, state_a},
               sig_a, {4'h0, 3'b000, ST_IDLE}, sig_hold);
    end
    run_check(4'h3, 1'b0, 15'($urandom), 1'b1, 1'b0, "after_abort");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_zero_response;
    test_seed_fixup;
    test_random;
    test_core;
    test_back_to_back;
    test_reset_mid_run;
`ifdef S27_BIST_ABORT_EN
    test_abort;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
